// File: rtl/matrix_batch_sequencer.sv
// Batch engine for the 2x2 matrix multiplier: walks input-memory words FIRST_ADDR..LAST_ADDR,
// multiplies the packed X and Y matrices and writes the four Z entries to the output memory.
module matrix_batch_sequencer #(
  parameter logic [3:0] FIRST_ADDR = 4'h0,
  parameter logic [3:0] LAST_ADDR  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        rd_en,
  output logic [3:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [1:0]      widx_q, widx_d;
  logic [15:0]     opnd_q, opnd_d;
  logic [3:0][4:0] z_q, z_d;

  function automatic logic [4:0] dot2(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic [1:0] d);
    return 5'(a) * 5'(b) + 5'(c) * 5'(d);
  endfunction

  // Byte 0 holds X, byte 1 holds Y; each byte is {D,C,B,A} for the matrix [[A,B],[C,D]].
  function automatic logic [3:0][4:0] mat_mul(input logic [15:0] w);
    logic [1:0]      ax, bx, cx, dx, ay, by, cy, dy;
    logic [3:0][4:0] z;
    {dx, cx, bx, ax} = w[7:0];
    {dy, cy, by, ay} = w[15:8];
    z[0] = dot2(ax, ay, bx, cy);
    z[1] = dot2(ax, by, bx, dy);
    z[2] = dot2(cx, ay, dx, cy);
    z[3] = dot2(cx, by, dx, dy);
    return z;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= FIRST_ADDR;
      widx_q  <= 2'd0;
      opnd_q  <= 16'd0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      opnd_q  <= opnd_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;
    opnd_d  = opnd_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = FIRST_ADDR;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        opnd_d  = rd_data;
        state_d = S_CALC;
      end
      S_CALC: begin
        z_d     = mat_mul(opnd_q);
        widx_d  = 2'd0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        widx_d = widx_q + 2'd1;
        if (widx_q == 2'd3) begin
          // Terminate on the address compare so LAST_ADDR = 4'hF never relies on ptr wrapping.
          if (ptr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + 4'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q inside {S_READ, S_LATCH, S_CALC, S_WRITE})) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    rd_addr = ptr_q;
    wr_addr = {ptr_q, widx_q};
    wr_data = {11'd0, z_q[widx_q]};
    case (state_q)
      S_READ:  begin rd_en = 1'b1; busy = 1'b1; end
      S_LATCH: begin rd_en = 1'b1; busy = 1'b1; end
      S_CALC:  busy = 1'b1;
      S_WRITE: begin wr_en = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_batch_sequencer.sv
// Bench for matrix_batch_sequencer: three instances (full range, word 0 only, word 5 only)
// share one memory image; expected writes go to a scoreboard queue when start is driven.
module tb_matrix_batch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        start_w   [3];
  logic        rd_en_w   [3];
  logic [3:0]  rd_addr_w [3];
  logic [15:0] rd_data_w [3];
  logic        wr_en_w   [3];
  logic [5:0]  wr_addr_w [3];
  logic [15:0] wr_data_w [3];
  logic        busy_w    [3];
  logic        done_w    [3];

  logic [15:0] mem [16];
  logic [21:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  matrix_batch_sequencer u_def (
    .clk(clk), .rst(rst), .start(start_w[0]), .abort(abort),
    .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
    .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  matrix_batch_sequencer #(.FIRST_ADDR(4'h0), .LAST_ADDR(4'h0)) u_w0 (
    .clk(clk), .rst(rst), .start(start_w[1]), .abort(abort),
    .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
    .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  matrix_batch_sequencer #(.FIRST_ADDR(4'h5), .LAST_ADDR(4'h5)) u_w5 (
    .clk(clk), .rst(rst), .start(start_w[2]), .abort(abort),
    .rd_en(rd_en_w[2]), .rd_addr(rd_addr_w[2]), .rd_data(rd_data_w[2]),
    .wr_en(wr_en_w[2]), .wr_addr(wr_addr_w[2]), .wr_data(wr_data_w[2]),
    .busy(busy_w[2]), .done(done_w[2])
  );

  // One-cycle read latency memory model per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_en_w[k]) rd_data_w[k] <= mem[rd_addr_w[k]];
    end
  end

  function automatic logic [15:0] zent(input logic [15:0] w, input int i);
    int ax, bx, cx, dx, ay, by, cy, dy, r;
    ax = int'(w[1:0]);  bx = int'(w[3:2]);  cx = int'(w[5:4]);   dx = int'(w[7:6]);
    ay = int'(w[9:8]);  by = int'(w[11:10]); cy = int'(w[13:12]); dy = int'(w[15:14]);
    case (i)
      0:       r = ax * ay + bx * cy;
      1:       r = ax * by + bx * dy;
      2:       r = cx * ay + dx * cy;
      default: r = cx * by + dx * dy;
    endcase
    return 16'(r);
  endfunction

  task automatic push_word(input int addr, input int n_ent);
    for (int i = 0; i < n_ent; i++) exp_q.push_back({6'(addr * 4 + i), zent(mem[addr], i)});
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    start_w[sel] = 1'b1;
    @(posedge clk);
    #1 start_w[sel] = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      got = {rd_en_w[s], wr_en_w[s], busy_w[s], done_w[s], rd_addr_w[s], wr_addr_w[s], wr_data_w[s][5:0]};
      checks++;
      if (got !== {4'b0000, 4'(s == 2 ? 5 : 0), 6'(s == 2 ? 8'h14 : 0), 6'd0}) begin
        errors++;
        $display("FAIL reset_state inst=%0d got=%h want zero outputs, base addr", s, got);
      end
    end
    // Reset asserted for two cycles starting in WRITE cycle 5.
    pulse_start(0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if ({rd_en_w[0], wr_en_w[0], busy_w[0], done_w[0], rd_addr_w[0], wr_addr_w[0], wr_data_w[0]} !== 30'd0) begin
          errors++;
          $display("FAIL reset_mid_write rd=%b wr=%b busy=%b done=%b rda=%h wra=%h wrd=%h want all 0",
                   rd_en_w[0], wr_en_w[0], busy_w[0], done_w[0], rd_addr_w[0], wr_addr_w[0], wr_data_w[0]);
        end
      end
      if (c >= 6) begin
        checks++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
          errors++;
          $display("FAIL reset_no_done cycle=%0d done=%b busy=%b want 0 0", c, done_w[0], busy_w[0]);
        end
      end
      rst = (c == 5 || c == 6);
    end
  endtask

  task automatic test_single_word(input int sel, input int addr, input logic [15:0] word,
                                  input logic [15:0] d0, input logic [15:0] d1,
                                  input logic [15:0] d2, input logic [15:0] d3);
    logic [3:0]  got, want;
    logic [21:0] e;
    mem[addr] = word;
    exp_q.push_back({6'(addr * 4 + 0), d0});
    exp_q.push_back({6'(addr * 4 + 1), d1});
    exp_q.push_back({6'(addr * 4 + 2), d2});
    exp_q.push_back({6'(addr * 4 + 3), d3});
    pulse_start(sel);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      got  = {rd_en_w[sel], wr_en_w[sel], busy_w[sel], done_w[sel]};
      want = {c <= 2, c >= 4 && c <= 7, c <= 7, c == 8};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single_ctrl addr=%0d cycle=%0d got rd,wr,busy,done=%b want %b", addr, c, got, want);
      end
      if (wr_en_w[sel] === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({wr_addr_w[sel], wr_data_w[sel]} !== e) begin
          errors++;
          $display("FAIL single_write cycle=%0d got addr=%h data=%h want addr=%h data=%h",
                   c, wr_addr_w[sel], wr_data_w[sel], e[21:16], e[15:0]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_count addr=%0d missing writes=%0d want 0", addr, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_full_batch(input bit inject_start);
    logic [3:0]  got, want;
    logic [21:0] e;
    int          ph;
    bit          act;
    for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
    for (int a = 0; a < 16; a++) push_word(a, 4);
    pulse_start(0);
    for (int c = 1; c <= 116; c++) begin
      @(negedge clk);
      ph   = (c - 1) % 7;
      act  = (c <= 112);
      got  = {rd_en_w[0], wr_en_w[0], busy_w[0], done_w[0]};
      want = {act && ph < 2, act && ph >= 3, act, c == 113};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL batch_ctrl inject=%0d cycle=%0d got rd,wr,busy,done=%b want %b", inject_start, c, got, want);
      end
      if (act && ph < 2) begin
        checks++;
        if (rd_addr_w[0] !== 4'((c - 1) / 7)) begin
          errors++;
          $display("FAIL batch_rd_addr cycle=%0d got %h want %h", c, rd_addr_w[0], 4'((c - 1) / 7));
        end
      end
      if (wr_en_w[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL batch_extra_write cycle=%0d addr=%h want no write", c, wr_addr_w[0]);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr_w[0], wr_data_w[0]} !== e) begin
            errors++;
            $display("FAIL batch_write cycle=%0d got addr=%h data=%h want addr=%h data=%h",
                     c, wr_addr_w[0], wr_data_w[0], e[21:16], e[15:0]);
          end
        end
      end
      start_w[0] = inject_start && (c == 3 || c == 50);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL batch_count missing writes=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort();
    logic [3:0]  got, want;
    logic [21:0] e;
    int          ph;
    for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
    push_word(0, 4);
    push_word(1, 2);
    pulse_start(0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ph   = (c - 1) % 7;
      got  = {rd_en_w[0], wr_en_w[0], busy_w[0], done_w[0]};
      want = (c <= 12) ? {ph < 2, ph >= 3, 1'b1, 1'b0} : 4'b0000;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL abort_ctrl cycle=%0d got rd,wr,busy,done=%b want %b", c, got, want);
      end
      if (wr_en_w[0] === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({wr_addr_w[0], wr_data_w[0]} !== e) begin
          errors++;
          $display("FAIL abort_write cycle=%0d got addr=%h data=%h want addr=%h data=%h",
                   c, wr_addr_w[0], wr_data_w[0], e[21:16], e[15:0]);
        end
      end
      abort = (c == 12);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_count missing writes=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    pulse_start(0);
    @(negedge clk);
    checks++;
    if (rd_en_w[0] !== 1'b1 || rd_addr_w[0] !== 4'h0) begin
      errors++;
      $display("FAIL restart_read got rd_en=%b rd_addr=%h want 1 0", rd_en_w[0], rd_addr_w[0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en_w[0] !== 1'b1 || wr_addr_w[0] !== 6'h00 || wr_data_w[0] !== zent(mem[0], 0)) begin
      errors++;
      $display("FAIL restart_write got wr_en=%b addr=%h data=%h want 1 00 %h",
               wr_en_w[0], wr_addr_w[0], wr_data_w[0], zent(mem[0], 0));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    abort = 1'b0;
    for (int s = 0; s < 3; s++) start_w[s] = 1'b0;
    for (int a = 0; a < 16; a++) mem[a] = 16'd0;
    test_reset();
    test_single_word(1, 0, 16'hF639, 16'h0008, 16'h0007, 16'h0006, 16'h0003);
    test_single_word(2, 5, 16'hFFFF, 16'h0012, 16'h0012, 16'h0012, 16'h0012);
    test_full_batch(1'b0);
    test_abort();
    test_full_batch(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_batch_sequencer.md
# matrix_batch_sequencer

Automatic batch engine placed between the 16-word input memory bank and the 64-location output memory of the 2x2 matrix multiplier. On a start pulse it walks a range of input-memory addresses, unpacks each 16-bit word into 2x2 matrices X and Y, computes Z = X·Y, and writes the four Z entries to the output memory. This replaces the per-address, button-driven write sequence.

## Interface
Parameters:
- FIRST_ADDR, 4'h0: first input-memory address processed.
- LAST_ADDR, 4'hF: last address processed. FIRST_ADDR <= LAST_ADDR is required.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; sampled in any busy state.
- rd_en  out  1  input-memory read strobe (output enable).
- rd_addr  out  4  input-memory address.
- rd_data  in  16  input-memory data, valid one cycle after rd_en.
- wr_en  out  1  output-memory write enable.
- wr_addr  out  6  output-memory address {word_addr[3:0], matrix_addr[1:0]}.
- wr_data  out  16  Z entry, zero-extended ({11'b0, z[4:0]}).
- busy  out  1  high in READ, LATCH, CALC and WRITE.
- done  out  1  one-cycle completion pulse.

## Operation
- Word packing: rd_data[7:0] = {Dx,Cx,Bx,Ax} and rd_data[15:8] = {Dy,Cy,By,Ay}. All fields are 2-bit unsigned. X = [[Ax,Bx],[Cx,Dx]], and Y is arranged the same way.
- Z entries, each 5-bit unsigned, computed at full precision. The maximum is 3·3+3·3 = 18, so no overflow is possible:
  - Az = Ax·Ay + Bx·Cy
  - Bz = Ax·By + Bx·Dy
  - Cz = Cx·Ay + Dx·Cy
  - Dz = Cx·By + Dx·Dy
- Matrix_addr mapping: 0 = Az, 1 = Bz, 2 = Cz, 3 = Dz.
- FSM states: IDLE, READ, LATCH, CALC, WRITE, DONE.
  - IDLE: if start is high, ptr <= FIRST_ADDR and the next state is READ.
  - READ: rd_en = 1 and rd_addr = ptr. Next state is LATCH.
  - LATCH: rd_en = 1 and rd_addr = ptr. The memory drives rd_data during this cycle. X/Y operand registers load from rd_data at the end of the cycle. Next state is CALC.
  - CALC: Az..Dz are computed from the operand registers and registered at the end of the cycle. widx <= 0. Next state is WRITE.
  - WRITE: wr_en = 1, wr_addr = {ptr, widx}, wr_data = {11'b0, Z[widx]}, and widx increments each cycle. After the cycle with widx = 3:
    - if ptr == LAST_ADDR, go to DONE;
    - otherwise ptr <= ptr + 1 and go to READ.
  - DONE: done = 1 and busy = 0. Next state is IDLE.
- Outputs are Moore outputs (decoded from registered state only). rd_addr and wr_addr are driven from the registered ptr and widx.
- rd_en and wr_en are never high in the same cycle.
- start while not in IDLE: ignored. No queuing.
- start and abort together in IDLE: start wins. abort is ignored outside busy states.
- abort in a busy state: next state is IDLE, with no done pulse.
  - The write in progress in that cycle still completes.
  - Output locations already written keep their values.
- rst mid-operation: next state is IDLE. The write, if any, completes in that cycle.
- ptr never wraps. The LAST_ADDR = 4'hF case terminates via the DONE transition, not by overflow.

## Timing
- Reset values: state = IDLE, ptr = FIRST_ADDR, widx = 0, operand and Z registers = 0.
  - Outputs after reset: rd_en = 0, wr_en = 0, busy = 0, done = 0, rd_addr = FIRST_ADDR, wr_addr = {FIRST_ADDR, 2'b0}, wr_data = 0.
- Let E0 be the edge at which start is sampled:
  - READ occupies cycle 1 (E0 to E1), LATCH cycle 2, CALC cycle 3, WRITE cycles 4–7.
  - The next word's READ is cycle 8.
- Per word: 7 cycles. N = LAST_ADDR − FIRST_ADDR + 1.
  - DONE occupies cycle 7N+1, and done is high during that cycle.
  - Default configuration: done is high in cycle 113.
- busy rises in the cycle after the start edge and falls when DONE is entered.
- Read latency assumed by the block: exactly 1 cycle from rd_en/rd_addr to valid rd_data.

## Test plan
- Reset: assert rst for 2 cycles mid-WRITE -> all outputs return to their reset values the next cycle, and no done pulse is seen.
- Single word: FIRST = LAST = 0, mem[0] = 16'hF639 -> writes to addresses 0x00–0x03 with data 0x0008, 0x0007, 0x0006, 0x0003 in cycles 4–7; done pulses in cycle 8.
- Maximum values: mem[5] = 16'hFFFF with FIRST = LAST = 5 -> four writes of 0x0012 at addresses 0x14–0x17.
- Full batch: default parameters with random memory contents -> 64 writes, each matching the reference model, with addresses ascending 0x00..0x3F; done is high in cycle 113 only; busy is high in cycles 1–112.
- Abort: assert abort during the second word's WRITE with widx = 1 -> the widx = 1 write completes; IDLE is entered next cycle; no done pulse; a later start restarts at FIRST_ADDR.
- Start while busy: start pulses at cycles 3 and 50 -> no effect on the sequence or timing; rd_en and wr_en are never high together throughout.
